// File: rtl/e203_exu_oitf_tracker_if.sv
// Dispatch <-> OITF handshake bundle: allocation request with hazard operands, plus the in-order retire port.
// The dispatch stage is the master and the OITF tracker is the slave.
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

interface e203_exu_oitf_tracker_if #(
    parameter int ITAG_W = 1
);
    logic                          disp_oitf_ena;
    logic                          disp_oitf_ready;
    logic [ITAG_W-1:0]             disp_oitf_ptr;
    logic                          disp_oitf_rs1en;
    logic                          disp_oitf_rs2en;
    logic                          disp_oitf_rs3en;
    logic                          disp_oitf_rs1fpu;
    logic                          disp_oitf_rs2fpu;
    logic                          disp_oitf_rs3fpu;
    logic [`E203_RFIDX_WIDTH-1:0]  disp_oitf_rs1idx;
    logic [`E203_RFIDX_WIDTH-1:0]  disp_oitf_rs2idx;
    logic [`E203_RFIDX_WIDTH-1:0]  disp_oitf_rs3idx;
    logic                          disp_oitf_rdwen;
    logic                          disp_oitf_rdfpu;
    logic [`E203_RFIDX_WIDTH-1:0]  disp_oitf_rdidx;
    logic [`E203_PC_SIZE-1:0]      disp_oitf_pc;
    logic                          oitfrd_match_disprs1;
    logic                          oitfrd_match_disprs2;
    logic                          oitfrd_match_disprs3;
    logic                          oitfrd_match_disprd;
    logic                          oitf_ret_ena;
    logic [ITAG_W-1:0]             oitf_ret_ptr;
    logic                          oitf_ret_rdwen;
    logic                          oitf_ret_rdfpu;
    logic [`E203_RFIDX_WIDTH-1:0]  oitf_ret_rdidx;
    logic [`E203_PC_SIZE-1:0]      oitf_ret_pc;
    logic                          oitf_empty;

    modport master (
        output disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rs3en,
               disp_oitf_rs1fpu, disp_oitf_rs2fpu, disp_oitf_rs3fpu,
               disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rs3idx,
               disp_oitf_rdwen, disp_oitf_rdfpu, disp_oitf_rdidx, disp_oitf_pc, oitf_ret_ena,
        input  disp_oitf_ready, disp_oitf_ptr,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
               oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_rdidx, oitf_ret_pc, oitf_empty
    );

    modport slave (
        input  disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rs3en,
               disp_oitf_rs1fpu, disp_oitf_rs2fpu, disp_oitf_rs3fpu,
               disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rs3idx,
               disp_oitf_rdwen, disp_oitf_rdfpu, disp_oitf_rdidx, disp_oitf_pc, oitf_ret_ena,
        output disp_oitf_ready, disp_oitf_ptr,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
               oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_rdidx, oitf_ret_pc, oitf_empty
    );
endinterface

// File: rtl/e203_exu_oitf_tracker.sv
// Outstanding-instruction tracking FIFO for long-pipe ops: in-order alloc/retire with RAW/WAW hazard lookup.
// Optional macro E203_OITF_PC_EN adds per-entry PC storage; otherwise oitf_ret_pc reads as zero.
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_exu_oitf_tracker #(
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_W     = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    e203_exu_oitf_tracker_if.slave   oitf
);

    localparam int RFIDX_W = `E203_RFIDX_WIDTH;
    localparam int PC_W    = `E203_PC_SIZE;

    logic                vld_r   [OITF_DEPTH];
    logic                rdwen_r [OITF_DEPTH];
    logic                rdfpu_r [OITF_DEPTH];
    logic [RFIDX_W-1:0]  rdidx_r [OITF_DEPTH];

    logic [ITAG_W-1:0]   alc_ptr_r;
    logic [ITAG_W-1:0]   ret_ptr_r;
    logic                alc_flg_r;
    logic                ret_flg_r;

    logic                empty_s;
    logic                full_s;
    logic                alc_vld_s;
    logic                ret_vld_s;
    logic [ITAG_W:0]     alc_nxt_s;
    logic [ITAG_W:0]     ret_nxt_s;
    logic                hit_rs1_s;
    logic                hit_rs2_s;
    logic                hit_rs3_s;
    logic                hit_rd_s;

    // Advance a pointer, wrapping at the last entry and toggling the wrap flag; returns {flag, ptr}.
    function automatic logic [ITAG_W:0] ptr_inc(input logic [ITAG_W-1:0] ptr, input logic flg);
        logic [ITAG_W:0] res;
        if (ptr == ITAG_W'(OITF_DEPTH - 1)) begin
            res = {~flg, {ITAG_W{1'b0}}};
        end else begin
            res = {flg, ptr + ITAG_W'(1)};
        end
        return res;
    endfunction

    assign empty_s   = (alc_ptr_r == ret_ptr_r) && (alc_flg_r == ret_flg_r);
    assign full_s    = (alc_ptr_r == ret_ptr_r) && (alc_flg_r != ret_flg_r);
    assign alc_vld_s = oitf.disp_oitf_ena & ~full_s;
    assign ret_vld_s = oitf.oitf_ret_ena & ~empty_s;
    assign alc_nxt_s = ptr_inc(alc_ptr_r, alc_flg_r);
    assign ret_nxt_s = ptr_inc(ret_ptr_r, ret_flg_r);

    // Allocation and retire pointers with their wrap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr_r <= {ITAG_W{1'b0}};
            alc_flg_r <= 1'b0;
            ret_ptr_r <= {ITAG_W{1'b0}};
            ret_flg_r <= 1'b0;
        end else begin
            if (alc_vld_s) begin
                {alc_flg_r, alc_ptr_r} <= alc_nxt_s;
            end
            if (ret_vld_s) begin
                {ret_flg_r, ret_ptr_r} <= ret_nxt_s;
            end
        end
    end

    // Entry valid bits and rd payload; alloc and retire never hit the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                vld_r[i]   <= 1'b0;
                rdwen_r[i] <= 1'b0;
                rdfpu_r[i] <= 1'b0;
                rdidx_r[i] <= {RFIDX_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (alc_vld_s && (alc_ptr_r == ITAG_W'(i))) begin
                    vld_r[i]   <= 1'b1;
                    rdwen_r[i] <= oitf.disp_oitf_rdwen;
                    rdfpu_r[i] <= oitf.disp_oitf_rdfpu;
                    rdidx_r[i] <= oitf.disp_oitf_rdidx;
                end else if (ret_vld_s && (ret_ptr_r == ITAG_W'(i))) begin
                    vld_r[i]   <= 1'b0;
                end
            end
        end
    end

`ifdef E203_OITF_PC_EN
    logic [PC_W-1:0] pc_r [OITF_DEPTH];

    // Per-entry PC captured at allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                pc_r[i] <= {PC_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (alc_vld_s && (alc_ptr_r == ITAG_W'(i))) begin
                    pc_r[i] <= oitf.disp_oitf_pc;
                end
            end
        end
    end

    assign oitf.oitf_ret_pc = pc_r[ret_ptr_r];
`else
    logic unused_pc_s;
    assign unused_pc_s      = ^oitf.disp_oitf_pc;
    assign oitf.oitf_ret_pc = {PC_W{1'b0}};
`endif

    // Hazard lookup: any valid rd-writing entry whose register (index and file) matches the operand.
    always_comb begin
        hit_rs1_s = 1'b0;
        hit_rs2_s = 1'b0;
        hit_rs3_s = 1'b0;
        hit_rd_s  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            hit_rs1_s = hit_rs1_s | (vld_r[i] & rdwen_r[i] & (rdidx_r[i] == oitf.disp_oitf_rs1idx)
                                     & (rdfpu_r[i] == oitf.disp_oitf_rs1fpu));
            hit_rs2_s = hit_rs2_s | (vld_r[i] & rdwen_r[i] & (rdidx_r[i] == oitf.disp_oitf_rs2idx)
                                     & (rdfpu_r[i] == oitf.disp_oitf_rs2fpu));
            hit_rs3_s = hit_rs3_s | (vld_r[i] & rdwen_r[i] & (rdidx_r[i] == oitf.disp_oitf_rs3idx)
                                     & (rdfpu_r[i] == oitf.disp_oitf_rs3fpu));
            hit_rd_s  = hit_rd_s  | (vld_r[i] & rdwen_r[i] & (rdidx_r[i] == oitf.disp_oitf_rdidx)
                                     & (rdfpu_r[i] == oitf.disp_oitf_rdfpu));
        end
    end

    assign oitf.oitfrd_match_disprs1 = oitf.disp_oitf_rs1en & hit_rs1_s;
    assign oitf.oitfrd_match_disprs2 = oitf.disp_oitf_rs2en & hit_rs2_s;
    assign oitf.oitfrd_match_disprs3 = oitf.disp_oitf_rs3en & hit_rs3_s;
    assign oitf.oitfrd_match_disprd  = oitf.disp_oitf_rdwen & hit_rd_s;

    assign oitf.disp_oitf_ready = ~full_s;
    assign oitf.disp_oitf_ptr   = alc_ptr_r;
    assign oitf.oitf_empty      = empty_s;
    assign oitf.oitf_ret_ptr    = ret_ptr_r;
    assign oitf.oitf_ret_rdwen  = rdwen_r[ret_ptr_r];
    assign oitf.oitf_ret_rdfpu  = rdfpu_r[ret_ptr_r];
    assign oitf.oitf_ret_rdidx  = rdidx_r[ret_ptr_r];

endmodule

// File: tb/tb_e203_exu_oitf_tracker.sv
// Directed bench for the OITF tracker at depth 2: reset, fill/full, hazards, retire, wrap and PC payload.
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module tb_e203_exu_oitf_tracker;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   err_cnt;
    logic [31:0] pc_a;
    logic [31:0] pc_b;

    e203_exu_oitf_tracker_if #(.ITAG_W(1)) oitf_bus ();

    e203_exu_oitf_tracker #(.OITF_DEPTH(2), .ITAG_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .oitf  (oitf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef E203_OITF_PC_EN
        return pc;
`else
        return 32'h0 & pc;
`endif
    endfunction

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        pc_a      = 32'h8000_0010;
        pc_b      = 32'h8000_0020;
        rst_n     = 1'b0;
        oitf_bus.disp_oitf_ena    = 1'b0;
        oitf_bus.disp_oitf_rs1en  = 1'b0;
        oitf_bus.disp_oitf_rs2en  = 1'b0;
        oitf_bus.disp_oitf_rs3en  = 1'b0;
        oitf_bus.disp_oitf_rs1fpu = 1'b0;
        oitf_bus.disp_oitf_rs2fpu = 1'b0;
        oitf_bus.disp_oitf_rs3fpu = 1'b0;
        oitf_bus.disp_oitf_rs1idx = 5'd0;
        oitf_bus.disp_oitf_rs2idx = 5'd0;
        oitf_bus.disp_oitf_rs3idx = 5'd0;
        oitf_bus.disp_oitf_rdwen  = 1'b0;
        oitf_bus.disp_oitf_rdfpu  = 1'b0;
        oitf_bus.disp_oitf_rdidx  = 5'd0;
        oitf_bus.disp_oitf_pc     = 32'h0;
        oitf_bus.oitf_ret_ena     = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 64'(oitf_bus.disp_oitf_ready), 64'd1);
        chk("rst_empty", 64'(oitf_bus.oitf_empty), 64'd1);
        chk("rst_alc_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        chk("rst_ret_ptr", 64'(oitf_bus.oitf_ret_ptr), 64'd0);
        chk("rst_matches", 64'({oitf_bus.oitfrd_match_disprs1, oitf_bus.oitfrd_match_disprs2,
                                oitf_bus.oitfrd_match_disprs3, oitf_bus.oitfrd_match_disprd}), 64'd0);
        chk("rst_ret_rdidx", 64'(oitf_bus.oitf_ret_rdidx), 64'd0);
        chk("rst_ret_pc", 64'(oitf_bus.oitf_ret_pc), 64'd0);
        rst_n = 1'b1;
        tick();

        // Fill: x5 then x6, third allocation while full must be dropped
        oitf_bus.disp_oitf_ena   = 1'b1;
        oitf_bus.disp_oitf_rdwen = 1'b1;
        oitf_bus.disp_oitf_rdidx = 5'd5;
        oitf_bus.disp_oitf_pc    = pc_a;
        #1;
        chk("alc0_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        tick();
        chk("alc1_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd1);
        chk("alc1_empty", 64'(oitf_bus.oitf_empty), 64'd0);
        chk("alc1_ready", 64'(oitf_bus.disp_oitf_ready), 64'd1);
        chk("alc1_ret_rdidx", 64'(oitf_bus.oitf_ret_rdidx), 64'd5);
        chk("alc1_ret_rdwen", 64'(oitf_bus.oitf_ret_rdwen), 64'd1);
        chk("alc1_ret_pc", 64'(oitf_bus.oitf_ret_pc), 64'(exp_pc(pc_a)));
        oitf_bus.disp_oitf_rdidx = 5'd6;
        oitf_bus.disp_oitf_pc    = pc_b;
        tick();
        chk("full_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        chk("full_ready", 64'(oitf_bus.disp_oitf_ready), 64'd0);
        oitf_bus.disp_oitf_rdidx = 5'd7;
        tick();
        chk("full_ign_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        chk("full_ign_ready", 64'(oitf_bus.disp_oitf_ready), 64'd0);
        chk("full_ign_head", 64'(oitf_bus.oitf_ret_rdidx), 64'd5);
        chk("full_ign_empty", 64'(oitf_bus.oitf_empty), 64'd0);
        oitf_bus.disp_oitf_ena   = 1'b0;
        oitf_bus.disp_oitf_rdwen = 1'b0;

        // Hazards against outstanding x5/x6 (x7 was never accepted)
        oitf_bus.disp_oitf_rs1en  = 1'b1;
        oitf_bus.disp_oitf_rs1idx = 5'd5;
        #1;
        chk("raw_rs1_hit", 64'(oitf_bus.oitfrd_match_disprs1), 64'd1);
        oitf_bus.disp_oitf_rs1fpu = 1'b1;
        #1;
        chk("raw_rs1_fpu", 64'(oitf_bus.oitfrd_match_disprs1), 64'd0);
        oitf_bus.disp_oitf_rs1fpu = 1'b0;
        oitf_bus.disp_oitf_rs1en  = 1'b0;
        #1;
        chk("raw_rs1_noen", 64'(oitf_bus.oitfrd_match_disprs1), 64'd0);
        oitf_bus.disp_oitf_rs2en  = 1'b1;
        oitf_bus.disp_oitf_rs2idx = 5'd6;
        oitf_bus.disp_oitf_rs3en  = 1'b1;
        oitf_bus.disp_oitf_rs3idx = 5'd7;
        #1;
        chk("raw_rs2_hit", 64'(oitf_bus.oitfrd_match_disprs2), 64'd1);
        chk("raw_rs3_miss", 64'(oitf_bus.oitfrd_match_disprs3), 64'd0);
        oitf_bus.disp_oitf_rs2en = 1'b0;
        oitf_bus.disp_oitf_rs3en = 1'b0;
        oitf_bus.disp_oitf_rdwen = 1'b1;
        oitf_bus.disp_oitf_rdidx = 5'd5;
        #1;
        chk("waw_rd_hit", 64'(oitf_bus.oitfrd_match_disprd), 64'd1);
        oitf_bus.disp_oitf_rdfpu = 1'b1;
        #1;
        chk("waw_rd_fpu", 64'(oitf_bus.oitfrd_match_disprd), 64'd0);
        oitf_bus.disp_oitf_rdfpu = 1'b0;

        // Full: retire and allocate together -> only the retire happens
        oitf_bus.oitf_ret_ena    = 1'b1;
        oitf_bus.disp_oitf_ena   = 1'b1;
        oitf_bus.disp_oitf_rdidx = 5'd9;
        tick();
        oitf_bus.oitf_ret_ena    = 1'b0;
        oitf_bus.disp_oitf_ena   = 1'b0;
        oitf_bus.disp_oitf_rdidx = 5'd5;
        #1;
        chk("ret_ready", 64'(oitf_bus.disp_oitf_ready), 64'd1);
        chk("ret_ptr", 64'(oitf_bus.oitf_ret_ptr), 64'd1);
        chk("ret_rdidx", 64'(oitf_bus.oitf_ret_rdidx), 64'd6);
        chk("ret_alc_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        chk("ret_x5_gone", 64'(oitf_bus.oitfrd_match_disprd), 64'd0);
        chk("ret_ret_pc", 64'(oitf_bus.oitf_ret_pc), 64'(exp_pc(pc_b)));

        // One entry outstanding, alloc+retire together for 5 cycles
        oitf_bus.disp_oitf_ena = 1'b1;
        oitf_bus.oitf_ret_ena  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            oitf_bus.disp_oitf_rdidx = 5'(10 + i);
            tick();
            chk("wrap_empty", 64'(oitf_bus.oitf_empty), 64'd0);
            chk("wrap_ready", 64'(oitf_bus.disp_oitf_ready), 64'd1);
            chk("wrap_alc_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'((i + 1) % 2));
            chk("wrap_ret_ptr", 64'(oitf_bus.oitf_ret_ptr), 64'(i % 2));
            chk("wrap_head", 64'(oitf_bus.oitf_ret_rdidx), 64'(10 + i));
        end

        // Drain, then retire while empty is ignored
        oitf_bus.disp_oitf_ena = 1'b0;
        tick();
        chk("drain_empty", 64'(oitf_bus.oitf_empty), 64'd1);
        chk("drain_ret_ptr", 64'(oitf_bus.oitf_ret_ptr), 64'd1);
        chk("drain_ready", 64'(oitf_bus.disp_oitf_ready), 64'd1);
        tick();
        chk("mt_ret_ptr", 64'(oitf_bus.oitf_ret_ptr), 64'd1);
        chk("mt_empty", 64'(oitf_bus.oitf_empty), 64'd1);
        oitf_bus.oitf_ret_ena    = 1'b0;
        oitf_bus.disp_oitf_rdidx = 5'd14;
        #1;
        chk("mt_no_match", 64'(oitf_bus.oitfrd_match_disprd), 64'd0);

        // Allocate into the empty queue then reset mid-operation
        oitf_bus.disp_oitf_ena = 1'b1;
        tick();
        oitf_bus.disp_oitf_ena = 1'b0;
        #1;
        chk("pre_rst_match", 64'(oitf_bus.oitfrd_match_disprd), 64'd1);
        chk("pre_rst_alc_ptr", 64'(oitf_bus.disp_oitf_ptr), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 64'(oitf_bus.oitf_empty), 64'd1);
        chk("mid_rst_ptrs", 64'({oitf_bus.disp_oitf_ptr, oitf_bus.oitf_ret_ptr}), 64'd0);
        chk("mid_rst_match", 64'(oitf_bus.oitfrd_match_disprd), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
